// File: rtl/overlay_fetch_arb.sv
// Overlay SDRAM port arbiter: download byte writes win over display prefetch reads into a show-ahead FIFO.
// Optional build macro OVERLAY_UNDERRUN_CNT_EN adds the saturating underrun_cnt output.
`timescale 1ns/1ps

module overlay_fetch_arb #(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 25
) (
    input  logic              clk_48,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_busy,
    input  logic              fetch_en,
    input  logic              vsync,
    input  logic              pix_rd,
    output logic [15:0]       pix_data,
    output logic              pix_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic [15:0]       mem_dout,
    input  logic              mem_ready
`ifdef OVERLAY_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_cnt
`endif
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_WAIT = 2'd1,
        ST_RD_WAIT = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   hold_addr_r;
    logic [7:0]          hold_data_r;
    logic                vsync_r;
    logic                vsync_prev_r;
    logic [ADDR_W-1:0]   rd_ptr_r;
    logic                drop_r;
    logic [15:0]         fifo_mem_r [FIFO_DEPTH];
    logic [IDX_W-1:0]    wr_idx_r;
    logic [IDX_W-1:0]    rd_idx_r;
    logic [CNT_W-1:0]    count_r;

    logic                edge_s;
    logic                flush_s;
    logic                capture_s;
    logic                rd_done_s;
    logic                push_s;
    logic                pop_s;
    logic                issue_wr_s;
    logic                issue_rd_s;
    logic [CNT_W-1:0]    count_n_s;
    logic [IDX_W-1:0]    wr_idx_n_s;
    logic [IDX_W-1:0]    rd_idx_n_s;
    logic [15:0]         head_n_s;

    // Event decode: vsync edge, flush, holding-register capture, FIFO push/pop.
    always_comb begin
        edge_s    = vsync_r & ~vsync_prev_r;
        // fetch_en low behaves as a continuous flush
        flush_s   = edge_s | ~fetch_en;
        capture_s = wr_req & ~wr_busy;
        rd_done_s = mem_ready & (state_r == ST_RD_WAIT);
        push_s    = rd_done_s & ~drop_r & ~flush_s;
        pop_s     = pix_rd & (count_r != {CNT_W{1'b0}}) & ~flush_s;
    end

    // Arbitration FSM next state; an incoming write strobe also blocks a read so writes always win.
    always_comb begin
        state_s    = state_r;
        issue_wr_s = 1'b0;
        issue_rd_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (wr_busy) begin
                    issue_wr_s = 1'b1;
                    state_s    = ST_WR_WAIT;
                end else if (!flush_s && !capture_s && (count_r < CNT_W'(FIFO_DEPTH))) begin
                    issue_rd_s = 1'b1;
                    state_s    = ST_RD_WAIT;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_WR_WAIT: begin
                if (mem_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WR_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (mem_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RD_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FIFO pointer/count next values and the registered show-ahead head word.
    always_comb begin
        if (flush_s) begin
            count_n_s  = {CNT_W{1'b0}};
            wr_idx_n_s = {IDX_W{1'b0}};
            rd_idx_n_s = {IDX_W{1'b0}};
        end else begin
            count_n_s  = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
            wr_idx_n_s = wr_idx_r + IDX_W'(push_s);
            rd_idx_n_s = rd_idx_r + IDX_W'(pop_s);
        end
        if (count_n_s == {CNT_W{1'b0}}) begin
            head_n_s = 16'h0000;
        end else if (push_s && (wr_idx_r == rd_idx_n_s)) begin
            head_n_s = mem_dout;
        end else begin
            head_n_s = fifo_mem_r[rd_idx_n_s];
        end
    end

    // FSM state register.
    always_ff @(posedge clk_48 or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Write holding register and vsync edge synchroniser.
    always_ff @(posedge clk_48 or posedge reset) begin
        if (reset) begin
            wr_busy      <= 1'b0;
            hold_addr_r  <= {ADDR_W{1'b0}};
            hold_data_r  <= 8'h00;
            vsync_r      <= 1'b0;
            vsync_prev_r <= 1'b0;
        end else begin
            vsync_r      <= vsync;
            vsync_prev_r <= vsync_r;
            if (capture_s) begin
                wr_busy     <= 1'b1;
                hold_addr_r <= wr_addr;
                hold_data_r <= wr_data;
            end else if ((state_r == ST_WR_WAIT) && mem_ready) begin
                wr_busy <= 1'b0;
            end
        end
    end

    // Read pointer and drop flag; a dropped word does not advance the pointer.
    always_ff @(posedge clk_48 or posedge reset) begin
        if (reset) begin
            rd_ptr_r <= {ADDR_W{1'b0}};
            drop_r   <= 1'b0;
        end else begin
            if (flush_s) begin
                rd_ptr_r <= {ADDR_W{1'b0}};
            end else if (rd_done_s && !drop_r) begin
                rd_ptr_r <= rd_ptr_r + ADDR_W'(2);
            end
            if (rd_done_s) begin
                drop_r <= 1'b0;
            end else if (flush_s && (state_r == ST_RD_WAIT)) begin
                drop_r <= 1'b1;
            end
        end
    end

    // SDRAM request outputs, held stable from issue until completion.
    always_ff @(posedge clk_48 or posedge reset) begin
        if (reset) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= {ADDR_W{1'b0}};
            mem_din  <= 8'h00;
        end else begin
            mem_req <= issue_wr_s | issue_rd_s;
            if (issue_wr_s) begin
                mem_we   <= 1'b1;
                mem_addr <= hold_addr_r;
                mem_din  <= hold_data_r;
            end else if (issue_rd_s) begin
                mem_we   <= 1'b0;
                mem_addr <= rd_ptr_r;
                mem_din  <= 8'h00;
            end
        end
    end

    // Prefetch FIFO storage, pointers and registered head/valid outputs.
    always_ff @(posedge clk_48 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= 16'h0000;
            end
            wr_idx_r  <= {IDX_W{1'b0}};
            rd_idx_r  <= {IDX_W{1'b0}};
            count_r   <= {CNT_W{1'b0}};
            pix_data  <= 16'h0000;
            pix_valid <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_idx_r] <= mem_dout;
            end
            wr_idx_r  <= wr_idx_n_s;
            rd_idx_r  <= rd_idx_n_s;
            count_r   <= count_n_s;
            pix_data  <= head_n_s;
            pix_valid <= (count_n_s != {CNT_W{1'b0}});
        end
    end

`ifdef OVERLAY_UNDERRUN_CNT_EN
    // Saturating count of pops on an empty FIFO, cleared per frame.
    always_ff @(posedge clk_48 or posedge reset) begin
        if (reset) begin
            underrun_cnt <= 16'h0000;
        end else if (edge_s) begin
            underrun_cnt <= 16'h0000;
        end else if (pix_rd && (count_r == {CNT_W{1'b0}}) && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_overlay_fetch_arb.sv
// Directed bench for overlay_fetch_arb: main instance plus a narrow-address instance for pointer wrap.
`timescale 1ns/1ps

module tb_overlay_fetch_arb;

    logic        clk_48 = 1'b0;
    logic        reset = 1'b1;
    logic        wr_req = 1'b0;
    logic [24:0] wr_addr = 25'h0;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_busy;
    logic        fetch_en = 1'b0;
    logic        vsync = 1'b0;
    logic        pix_rd = 1'b0;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        mem_req;
    logic        mem_we;
    logic [24:0] mem_addr;
    logic [7:0]  mem_din;
    logic [15:0] mem_dout = 16'h0000;
    logic        mem_ready = 1'b0;

    logic        reset2 = 1'b1;
    logic        fetch_en2 = 1'b0;
    logic        wr_busy2;
    logic [15:0] pix_data2;
    logic        pix_valid2;
    logic        m2_req;
    logic        m2_we;
    logic [3:0]  m2_addr;
    logic [7:0]  m2_din;
    logic [15:0] m2_dout = 16'h0000;
    logic        m2_ready = 1'b0;
`ifdef OVERLAY_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
    logic [15:0] underrun_cnt2;
`endif

    int checks = 0;
    int failures = 0;
    int req_cnt = 0;
    int snap;
    bit found;
    logic [3:0] addr_q [$];

    overlay_fetch_arb #(.FIFO_DEPTH(8), .ADDR_W(25)) dut (
        .clk_48(clk_48), .reset(reset), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_busy(wr_busy), .fetch_en(fetch_en), .vsync(vsync),
        .pix_rd(pix_rd), .pix_data(pix_data), .pix_valid(pix_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_ready(mem_ready)
`ifdef OVERLAY_UNDERRUN_CNT_EN
        , .underrun_cnt(underrun_cnt)
`endif
    );

    overlay_fetch_arb #(.FIFO_DEPTH(4), .ADDR_W(4)) dut2 (
        .clk_48(clk_48), .reset(reset2), .wr_req(1'b0), .wr_addr(4'h0),
        .wr_data(8'h00), .wr_busy(wr_busy2), .fetch_en(fetch_en2), .vsync(1'b0),
        .pix_rd(1'b1), .pix_data(pix_data2), .pix_valid(pix_valid2),
        .mem_req(m2_req), .mem_we(m2_we), .mem_addr(m2_addr), .mem_din(m2_din),
        .mem_dout(m2_dout), .mem_ready(m2_ready)
`ifdef OVERLAY_UNDERRUN_CNT_EN
        , .underrun_cnt(underrun_cnt2)
`endif
    );

    always #5 clk_48 = ~clk_48;

    // SDRAM model: completes 3 cycles after each request, returns data equal to address.
    logic        r1_pend = 1'b0;
    logic [1:0]  r1_cnt = 2'd0;
    logic [24:0] r1_addr = 25'h0;
    always @(posedge clk_48) begin
        mem_ready <= 1'b0;
        if (mem_req) begin
            r1_pend <= 1'b1;
            r1_cnt  <= 2'd2;
            r1_addr <= mem_addr;
            req_cnt <= req_cnt + 1;
        end else if (r1_pend) begin
            if (r1_cnt == 2'd1) begin
                mem_ready <= 1'b1;
                mem_dout  <= r1_addr[15:0];
                r1_pend   <= 1'b0;
            end else begin
                r1_cnt <= r1_cnt - 2'd1;
            end
        end
    end

    logic        r2_pend = 1'b0;
    logic [1:0]  r2_cnt = 2'd0;
    logic [3:0]  r2_addr = 4'h0;
    always @(posedge clk_48) begin
        m2_ready <= 1'b0;
        if (m2_req) begin
            r2_pend <= 1'b1;
            r2_cnt  <= 2'd2;
            r2_addr <= m2_addr;
            if (addr_q.size() < 16) addr_q.push_back(m2_addr);
        end else if (r2_pend) begin
            if (r2_cnt == 2'd1) begin
                m2_ready <= 1'b1;
                m2_dout  <= {12'h000, r2_addr};
                r2_pend  <= 1'b0;
            end else begin
                r2_cnt <= r2_cnt - 2'd1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_48);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick(1);
            if (mem_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        tick(3);
        chk("rst_mem_req",   32'(mem_req),   32'd0);
        chk("rst_mem_we",    32'(mem_we),    32'd0);
        chk("rst_mem_addr",  32'(mem_addr),  32'd0);
        chk("rst_mem_din",   32'(mem_din),   32'd0);
        chk("rst_wr_busy",   32'(wr_busy),   32'd0);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_pix_data",  32'(pix_data),  32'd0);
        reset  = 1'b0;
        reset2 = 1'b0;
        fetch_en2 = 1'b1;

        // write and read eligibility in the same cycle: write must go first
        fetch_en = 1'b1;
        wr_req   = 1'b1;
        wr_addr  = 25'h0001234;
        wr_data  = 8'h5A;
        tick(1);
        wr_req = 1'b0;
        chk("prio_no_read", 32'(mem_req), 32'd0);
        chk("prio_busy",    32'(wr_busy), 32'd1);
        tick(1);
        chk("prio_req",  32'(mem_req),  32'd1);
        chk("prio_we",   32'(mem_we),   32'd1);
        chk("prio_addr", 32'(mem_addr), 32'h1234);
        chk("prio_din",  32'(mem_din),  32'h5A);

        // prefetch fill: eight reads at 0,2,..,14
        for (int i = 0; i < 8; i++) begin
            wait_req(30, found);
            chk("fill_req_seen", 32'(found), 32'd1);
            chk("fill_we",       32'(mem_we), 32'd0);
            chk("fill_addr",     32'(mem_addr), 32'(2 * i));
        end
        tick(2);
        snap = req_cnt;
        tick(20);
        chk("fill_no_ninth", 32'(req_cnt), 32'(snap));
        chk("fill_valid",    32'(pix_valid), 32'd1);
        chk("fill_head",     32'(pix_data),  32'h0000);
        pix_rd = 1'b1;
        tick(1);
        pix_rd = 1'b0;
        chk("pop_next_head", 32'(pix_data), 32'h0002);
        wait_req(10, found);
        chk("ninth_req_seen", 32'(found), 32'd1);
        chk("ninth_addr",     32'(mem_addr), 32'h10);

        // vsync edge while the read of 0x10 is in flight
        vsync = 1'b1;
        tick(2);
        chk("vs_flush_valid", 32'(pix_valid), 32'd0);
        chk("vs_flush_data",  32'(pix_data),  32'd0);
        tick(2);
        chk("vs_dropped", 32'(pix_valid), 32'd0);
        wait_req(10, found);
        chk("vs_req_seen", 32'(found), 32'd1);
        chk("vs_restart_addr", 32'(mem_addr), 32'd0);
        fetch_en = 1'b0;
        tick(8);

        // underrun: pop with FIFO empty
        pix_rd = 1'b1;
        tick(1);
        pix_rd = 1'b0;
        chk("under_valid", 32'(pix_valid), 32'd0);
        chk("under_data",  32'(pix_data),  32'd0);
`ifdef OVERLAY_UNDERRUN_CNT_EN
        chk("under_cnt", 32'(underrun_cnt), 32'd1);
`endif
        vsync = 1'b0;
        tick(2);
        vsync = 1'b1;
        tick(3);
`ifdef OVERLAY_UNDERRUN_CNT_EN
        chk("under_cnt_clr", 32'(underrun_cnt), 32'd0);
`endif

        // reset while a read is outstanding; its completion arrives after reset
        fetch_en = 1'b1;
        wait_req(10, found);
        chk("rmid_req_seen", 32'(found), 32'd1);
        tick(1);
        reset = 1'b1;
        #1;
        chk("rmid_mem_req",   32'(mem_req),   32'd0);
        chk("rmid_mem_we",    32'(mem_we),    32'd0);
        chk("rmid_mem_addr",  32'(mem_addr),  32'd0);
        chk("rmid_mem_din",   32'(mem_din),   32'd0);
        chk("rmid_wr_busy",   32'(wr_busy),   32'd0);
        chk("rmid_pix_valid", 32'(pix_valid), 32'd0);
        chk("rmid_pix_data",  32'(pix_data),  32'd0);
        fetch_en = 1'b0;
        snap = req_cnt;
        tick(1);
        reset = 1'b0;
        tick(6);
        chk("rmid_stale_noreq", 32'(req_cnt),  32'(snap));
        chk("rmid_stale_valid", 32'(pix_valid), 32'd0);

        // write latency from idle is exactly two cycles
        wr_req  = 1'b1;
        wr_addr = 25'h00000AB;
        wr_data = 8'h3C;
        tick(1);
        wr_req = 1'b0;
        chk("wr2_busy", 32'(wr_busy), 32'd1);
        tick(1);
        chk("wr2_req",  32'(mem_req),  32'd1);
        chk("wr2_we",   32'(mem_we),   32'd1);
        chk("wr2_addr", 32'(mem_addr), 32'hAB);
        chk("wr2_din",  32'(mem_din),  32'h3C);
        tick(6);
        chk("wr2_done", 32'(wr_busy), 32'd0);

        // narrow instance: pointer 14 (top of 4-bit space) wraps to 0
        chk("wrap_count", 32'(addr_q.size() >= 9), 32'd1);
        if (addr_q.size() >= 9) begin
            chk("wrap_last", 32'(addr_q[7]), 32'd14);
            chk("wrap_addr", 32'(addr_q[8]), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
